ct_width_narrow: RTL and testbench



---
 rtl/ct_width_narrow.sv | 122 ++++++++++++
 tb/tb_ct_width_narrow.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ct_width_narrow.sv
// ct_width_narrow: splits each WIDTH_IN-bit word from the clock-crossing
// FIFO read port into RATIO beats of WIDTH_OUT bits, slice 0 first.
// SR holds the word being emitted; PEND is a one-word skid so that the next
// word can be taken while SR drains. The word in SR is then reloaded with no
// bubble at the word end. o_ready comes only from registers, because the
// crossing's valid is combinational on its ready.
module ct_width_narrow #(
  parameter int WIDTH_IN  = 256,
  parameter int WIDTH_OUT = 64
) (
  input  logic                 clk,
  input  logic                 arst_n,
  input  logic [WIDTH_IN-1:0]  i_data,
  input  logic                 i_valid,
  output logic                 o_ready,
  output logic [WIDTH_OUT-1:0] o_data,
  output logic                 o_valid,
  output logic                 o_last,
  input  logic                 i_ready
);

  localparam int RATIO = WIDTH_IN / WIDTH_OUT;
  localparam int CNT_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RATIO - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(32'd0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);

  // The word must split into a whole number of beats, and at least two.
  if ((RATIO < 2) || (RATIO * WIDTH_OUT != WIDTH_IN)) begin : g_bad_ratio
    $error("ct_width_narrow: WIDTH_IN/WIDTH_OUT must be an integer >= 2");
  end

  logic [WIDTH_IN-1:0] sr_q, sr_d;
  logic [WIDTH_IN-1:0] pend_q, pend_d;
  logic                sr_valid_q, sr_valid_d;
  logic                pend_valid_q, pend_valid_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic fire_s;
  logic take_s;

  // A beat leaves when presented and accepted. A word is only taken while
  // PEND is free; a word offered while o_ready is low is ignored.
  assign fire_s = sr_valid_q & i_ready;
  assign take_s = i_valid & ~pend_valid_q;

  // Next-state logic for the shift register, beat counter and skid word.
  always_comb begin
    sr_d         = sr_q;
    sr_valid_d   = sr_valid_q;
    cnt_d        = cnt_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;

    if (!sr_valid_q) begin
      // Empty: a new word goes straight into SR, visible next cycle.
      if (take_s) begin
        sr_d       = i_data;
        sr_valid_d = 1'b1;
        cnt_d      = CNT_ZERO;
      end else begin
        sr_valid_d = 1'b0;
      end
    end else if (fire_s) begin
      if (cnt_q != CNT_LAST) begin
        // Mid-word beat: expose the next slice.
        sr_d  = sr_q >> WIDTH_OUT;
        cnt_d = cnt_q + CNT_ONE;
        if (take_s) begin
          pend_d       = i_data;
          pend_valid_d = 1'b1;
        end else begin
          pend_valid_d = pend_valid_q;
        end
      end else begin
        // Word end: reload from the skid first (older word), else from input.
        cnt_d = CNT_ZERO;
        if (pend_valid_q) begin
          sr_d         = pend_q;
          pend_valid_d = 1'b0;
        end else if (take_s) begin
          sr_d = i_data;
        end else begin
          sr_valid_d = 1'b0;
        end
      end
    end else begin
      // Stalled: SR and cnt hold; an arriving word parks in PEND.
      if (take_s) begin
        pend_d       = i_data;
        pend_valid_d = 1'b1;
      end else begin
        pend_valid_d = pend_valid_q;
      end
    end
  end

  // Control state: flags and beat counter, cleared by the async reset.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      sr_valid_q   <= 1'b0;
      pend_valid_q <= 1'b0;
      cnt_q        <= CNT_ZERO;
    end else begin
      sr_valid_q   <= sr_valid_d;
      pend_valid_q <= pend_valid_d;
      cnt_q        <= cnt_d;
    end
  end

  // Data storage: qualified by the flags, so it needs no reset.
  always_ff @(posedge clk) begin
    sr_q   <= sr_d;
    pend_q <= pend_d;
  end

  assign o_ready = ~pend_valid_q;
  assign o_data  = sr_q[WIDTH_OUT-1:0];
  assign o_valid = sr_valid_q;
  assign o_last  = sr_valid_q & (cnt_q == CNT_LAST);

endmodule

// File: tb/tb_ct_width_narrow.sv
// Testbench for ct_width_narrow. DUT a uses the default 256->64 split and
// takes the directed scenarios. DUT b uses a 256->128 split and takes the
// randomized run. Expected beats are derived from each issued word and pushed
// into a queue; monitors pop and compare on every accepted beat.
module tb_ct_width_narrow;

  logic clk;
  logic arst_n;

  logic [255:0] a_i_data;
  logic         a_i_valid;
  logic         a_o_ready;
  logic [63:0]  a_o_data;
  logic         a_o_valid;
  logic         a_o_last;
  logic         a_i_ready;

  logic [255:0] b_i_data;
  logic         b_i_valid;
  logic         b_o_ready;
  logic [127:0] b_o_data;
  logic         b_o_valid;
  logic         b_o_last;
  logic         b_i_ready;

  int checks = 0;
  int errors = 0;
  int beats_b = 0;

  logic [64:0]  q64[$];
  logic [128:0] q128[$];

  ct_width_narrow #(.WIDTH_IN(256), .WIDTH_OUT(64)) dut_a (
    .clk(clk), .arst_n(arst_n),
    .i_data(a_i_data), .i_valid(a_i_valid), .o_ready(a_o_ready),
    .o_data(a_o_data), .o_valid(a_o_valid), .o_last(a_o_last),
    .i_ready(a_i_ready)
  );

  ct_width_narrow #(.WIDTH_IN(256), .WIDTH_OUT(128)) dut_b (
    .clk(clk), .arst_n(arst_n),
    .i_data(b_i_data), .i_valid(b_i_valid), .o_ready(b_o_ready),
    .o_data(b_o_data), .o_valid(b_o_valid), .o_last(b_o_last),
    .i_ready(b_i_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic flag(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=beat expected=none", name);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [63:0] sl64(input logic [255:0] w, input int k);
    return w[k*64 +: 64];
  endfunction

  function automatic logic [255:0] rand_word();
    logic [255:0] w;
    for (int i = 0; i < 8; i++) w[i*32 +: 32] = $urandom();
    return w;
  endfunction

  // Offer a word to DUT a and record the four beats it must produce.
  task automatic send_a(input logic [255:0] w);
    a_i_data  = w;
    a_i_valid = 1'b1;
    for (int k = 0; k < 4; k++) q64.push_back({(k == 3), w[k*64 +: 64]});
  endtask

  // Offer a word to DUT b and record the two beats it must produce.
  task automatic send_b(input logic [255:0] w);
    b_i_data  = w;
    b_i_valid = 1'b1;
    for (int k = 0; k < 2; k++) q128.push_back({(k == 1), w[k*128 +: 128]});
  endtask

  task automatic drain(input int sel, input int budget);
    int n = 0;
    while (n < budget && (sel == 0 ? (q64.size() != 0) : (q128.size() != 0))) begin
      step(1);
      n++;
    end
    if (sel == 0) chk("a_drain_left", q64.size(), 0);
    else          chk("b_drain_left", q128.size(), 0);
  endtask

  // Monitor for DUT a: protocol check on offered words, scoreboard on beats.
  initial begin
    forever begin
      @(negedge clk);
      if (arst_n) begin
        if (a_i_valid) chk("a_proto_ready", a_o_ready, 1'b1);
        if (a_o_valid && a_i_ready) begin
          if (q64.size() == 0) flag("a_unexpected_beat");
          else chk("a_beat", {a_o_last, a_o_data}, q64.pop_front());
        end
      end
    end
  end

  // Monitor for DUT b: same checks, plus a count of accepted beats.
  initial begin
    forever begin
      @(negedge clk);
      if (arst_n) begin
        if (b_i_valid) chk("b_proto_ready", b_o_ready, 1'b1);
        if (b_o_valid && b_i_ready) begin
          beats_b++;
          if (q128.size() == 0) flag("b_unexpected_beat");
          else chk("b_beat", {b_o_last, b_o_data}, q128.pop_front());
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [255:0] w1, w2, w3, w4;
    int sent, cyc;
    w1 = {64'h4444444444444444, 64'h3333333333333333,
          64'h2222222222222222, 64'h1111111111111111};
    w2 = {64'h8888888888888888, 64'h7777777777777777,
          64'h6666666666666666, 64'h5555555555555555};
    w3 = {64'hdddddddddddddddd, 64'hcccccccccccccccc,
          64'hbbbbbbbbbbbbbbbb, 64'haaaaaaaaaaaaaaaa};
    w4 = {64'h0f0f0f0f0f0f0f0f, 64'h0e0e0e0e0e0e0e0e,
          64'h0d0d0d0d0d0d0d0d, 64'h0c0c0c0c0c0c0c0c};

    arst_n = 1'b0;
    a_i_data = 256'd0; a_i_valid = 1'b0; a_i_ready = 1'b1;
    b_i_data = 256'd0; b_i_valid = 1'b0; b_i_ready = 1'b1;
    step(3);
    chk("rst_a_valid", a_o_valid, 1'b0);
    chk("rst_a_last",  a_o_last,  1'b0);
    chk("rst_a_ready", a_o_ready, 1'b1);
    chk("rst_b_valid", b_o_valid, 1'b0);
    chk("rst_b_ready", b_o_ready, 1'b1);
    arst_n = 1'b1;
    step(1);

    // 1: single word, four beats starting the cycle after capture.
    send_a(w1);
    step(1);
    a_i_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("t1_valid", a_o_valid, 1'b1);
      chk("t1_data",  a_o_data,  sl64(w1, k));
      chk("t1_last",  a_o_last,  (k == 3));
      step(1);
    end
    chk("t1_idle", a_o_valid, 1'b0);

    // 2: back-to-back words, gapless beats and the o_ready dip.
    send_a(w1);
    step(1);
    chk("t2_valid_c1", a_o_valid, 1'b1);
    chk("t2_ready_c1", a_o_ready, 1'b1);
    send_a(w2);
    step(1);
    a_i_valid = 1'b0;
    for (int c = 2; c <= 9; c++) begin
      chk("t2_ready", a_o_ready, (c >= 5));
      chk("t2_valid", a_o_valid, (c <= 8));
      step(1);
    end
    drain(0, 20);

    // 3: stall after beat 1 for five cycles; output must freeze.
    send_a(w3);
    step(1);
    a_i_valid = 1'b0;
    step(1);
    a_i_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      chk("t3_hold_valid", a_o_valid, 1'b1);
      chk("t3_hold_data",  a_o_data,  sl64(w3, 1));
      chk("t3_hold_last",  a_o_last,  1'b0);
      step(1);
    end
    a_i_ready = 1'b1;
    chk("t3_resume_data", a_o_data, sl64(w3, 1));
    drain(0, 20);

    // 4: new word offered in the same cycle as a word-end fire, PEND empty.
    send_a(w1);
    step(1);
    a_i_valid = 1'b0;
    step(3);
    chk("t4_last_now", a_o_last, 1'b1);
    send_a(w2);
    step(1);
    a_i_valid = 1'b0;
    chk("t4_valid", a_o_valid, 1'b1);
    chk("t4_data",  a_o_data,  sl64(w2, 0));
    chk("t4_last",  a_o_last,  1'b0);
    drain(0, 20);

    // 5: reset after beat 2 of 4 with PEND full; clears without a clock edge.
    send_a(w1);
    step(1);
    send_a(w2);
    step(1);
    a_i_valid = 1'b0;
    step(1);
    chk("t5_pend_full", a_o_ready, 1'b0);
    chk("t5_beat2",     a_o_data,  sl64(w1, 2));
    #2;
    arst_n = 1'b0;
    #1;
    chk("t5_async_valid", a_o_valid, 1'b0);
    chk("t5_async_ready", a_o_ready, 1'b1);
    chk("t5_async_last",  a_o_last,  1'b0);
    q64.delete();
    step(2);
    arst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      chk("t5_no_stale", a_o_valid, 1'b0);
      chk("t5_ready",    a_o_ready, 1'b1);
      step(1);
    end
    send_a(w4);
    step(1);
    a_i_valid = 1'b0;
    drain(0, 20);

    // 6: randomized traffic on the 256->128 instance.
    sent = 0;
    cyc = 0;
    while (sent < 2000 && cyc < 40000) begin
      b_i_ready = ($urandom_range(0, 3) != 0);
      if (b_o_ready && ($urandom_range(0, 1) == 1)) begin
        send_b(rand_word());
        sent++;
      end else begin
        b_i_valid = 1'b0;
      end
      step(1);
      cyc++;
    end
    b_i_valid = 1'b0;
    b_i_ready = 1'b1;
    chk("t6_words_sent", sent, 2000);
    drain(1, 100);
    step(2);
    chk("t6_beats", beats_b, 4000);
    chk("t6_idle", b_o_valid, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
